// File: rtl/cordic_pkg.sv
// Constants shared by the rotation and vectoring CORDIC cores.
// Angles use 2^DW_NOR units per full turn.
package cordic_pkg;

    localparam int DW_NOR   = 20;
    localparam int K_Q16    = 39797;
    localparam int ATAN_NUM = 18;

    typedef enum logic [1:0] {QUAD_0, QUAD_1, QUAD_2, QUAD_3} quad_t;

    // atan(2^-i) in turn units, rounded to nearest
    localparam logic [DW_NOR-1:0] ATAN [0:ATAN_NUM-1] = '{
        20'd131072, 20'd77376, 20'd40884, 20'd20753, 20'd10417, 20'd5213,
        20'd2607,   20'd1304,  20'd652,   20'd326,   20'd163,   20'd81,
        20'd41,     20'd20,    20'd10,    20'd5,     20'd3,     20'd1
    };

    function automatic logic signed [DW_NOR:0] atan_step(input int idx);
        return signed'({1'b0, ATAN[idx]});
    endfunction

endpackage

// File: rtl/cordic_rot_unit.sv
// One registered CORDIC micro-rotation: shift by P_IR_ID, step the residual by ATAN[P_IR_ID].
// Syncs ride along so every stage stays aligned with its data.
module cordic_rot_unit
    import cordic_pkg::*;
#(
    parameter int DW      = 22,
    parameter int P_IR_ID = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   src_vsync,
    input  logic                   src_hsync,
    input  logic signed [DW-1:0]   src_x,
    input  logic signed [DW-1:0]   src_y,
    input  logic signed [DW_NOR:0] src_z,
    output logic                   dst_vsync,
    output logic                   dst_hsync,
    output logic signed [DW-1:0]   dst_x,
    output logic signed [DW-1:0]   dst_y,
    output logic signed [DW_NOR:0] dst_z
);

    localparam logic signed [DW_NOR:0] STEP = atan_step(P_IR_ID);

    logic signed [DW-1:0] x_sh;
    logic signed [DW-1:0] y_sh;

    assign x_sh = src_x >>> P_IR_ID;
    assign y_sh = src_y >>> P_IR_ID;

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_vsync <= 1'b0;
            dst_hsync <= 1'b0;
            dst_x     <= '0;
            dst_y     <= '0;
            dst_z     <= '0;
        end else begin
            dst_vsync <= src_vsync;
            dst_hsync <= src_hsync;
            // non-negative residual rotates counter-clockwise
            if (!src_z[DW_NOR]) begin
                dst_x <= src_x - y_sh;
                dst_y <= src_y + x_sh;
                dst_z <= src_z - STEP;
            end else begin
                dst_x <= src_x + y_sh;
                dst_y <= src_y - x_sh;
                dst_z <= src_z + STEP;
            end
        end
    end

endmodule

// File: rtl/cordic_rotate_core.sv
// Rotation-mode CORDIC: (magnitude, angle) -> (x, y), one sample per clock.
// Quadrant stage, T_IR_NUM micro-rotations, then gain compensation; latency T_IR_NUM+2.
module cordic_rotate_core
    import cordic_pkg::*;
#(
    parameter int DW       = 16,
    parameter int DW_DOT   = 4,
    parameter int T_IR_NUM = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_vsync,
    input  logic                      din_hsync,
    input  logic [DW-1:0]             din_mag,
    input  logic [DW_NOR-1:0]         din_z,
    output logic                      dout_vsync,
    output logic                      dout_hsync,
    output logic signed [DW+DW_DOT:0] dout_x,
    output logic signed [DW+DW_DOT:0] dout_y
);

    localparam int W_OUT = DW + DW_DOT + 1;
    localparam int W_V   = W_OUT + 1;
    localparam int W_P   = W_V + 18;
    localparam logic signed [17:0]    K_S = 18'(K_Q16);
    localparam logic signed [W_P-1:0] RND = W_P'(32768);

    quad_t                  quad;
    logic signed [W_V-1:0]  m;
    logic signed [W_V-1:0]  x_start;
    logic signed [W_V-1:0]  y_start;

    logic                   vs_s0;
    logic                   hs_s0;
    logic signed [W_V-1:0]  x_s0;
    logic signed [W_V-1:0]  y_s0;
    logic signed [DW_NOR:0] z_s0;

    logic                   vs_p [0:T_IR_NUM];
    logic                   hs_p [0:T_IR_NUM];
    logic signed [W_V-1:0]  x_p  [0:T_IR_NUM];
    logic signed [W_V-1:0]  y_p  [0:T_IR_NUM];
    logic signed [DW_NOR:0] z_p  [0:T_IR_NUM];

    logic signed [W_P-1:0]  prod_x;
    logic signed [W_P-1:0]  prod_y;
    logic                   unused_bits;

    assign quad = quad_t'(din_z[DW_NOR-1 -: 2]);
    assign m    = signed'({2'b00, din_mag, {DW_DOT{1'b0}}});

    always_comb begin
        x_start = '0;
        y_start = '0;
        case (quad)
            QUAD_0:  x_start = m;
            QUAD_1:  y_start = m;
            QUAD_2:  x_start = -m;
            default: y_start = -m;
        endcase
    end

    // residual below 90 deg keeps the iterations inside their convergence range
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_s0 <= 1'b0;
            hs_s0 <= 1'b0;
            x_s0  <= '0;
            y_s0  <= '0;
            z_s0  <= '0;
        end else begin
            vs_s0 <= din_vsync;
            hs_s0 <= din_hsync;
            x_s0  <= x_start;
            y_s0  <= y_start;
            z_s0  <= signed'({3'b000, din_z[DW_NOR-3:0]});
        end
    end

    assign vs_p[0] = vs_s0;
    assign hs_p[0] = hs_s0;
    assign x_p[0]  = x_s0;
    assign y_p[0]  = y_s0;
    assign z_p[0]  = z_s0;

    for (genvar i = 0; i < T_IR_NUM; i++) begin : g_iter
        cordic_rot_unit #(
            .DW      (W_V),
            .P_IR_ID (i)
        ) u_rot (
            .clk       (clk),
            .rst       (rst),
            .src_vsync (vs_p[i]),
            .src_hsync (hs_p[i]),
            .src_x     (x_p[i]),
            .src_y     (y_p[i]),
            .src_z     (z_p[i]),
            .dst_vsync (vs_p[i+1]),
            .dst_hsync (hs_p[i+1]),
            .dst_x     (x_p[i+1]),
            .dst_y     (y_p[i+1]),
            .dst_z     (z_p[i+1])
        );
    end

    assign prod_x = W_P'(x_p[T_IR_NUM]) * W_P'(K_S) + RND;
    assign prod_y = W_P'(y_p[T_IR_NUM]) * W_P'(K_S) + RND;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_vsync <= 1'b0;
            dout_hsync <= 1'b0;
            dout_x     <= '0;
            dout_y     <= '0;
        end else begin
            dout_vsync <= vs_p[T_IR_NUM];
            dout_hsync <= hs_p[T_IR_NUM];
            dout_x     <= prod_x[16 +: W_OUT];
            dout_y     <= prod_y[16 +: W_OUT];
        end
    end

    assign unused_bits = ^{prod_x[W_P-1:W_OUT+16], prod_x[15:0],
                           prod_y[W_P-1:W_OUT+16], prod_y[15:0], z_p[T_IR_NUM]};

endmodule
